// File: rtl/ring_aligner_pkg.sv
// rtl/ring_aligner_pkg.sv - shared types, defaults and the ring/reference neighbour check.
package ring_aligner_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int DEF_N    = 4;
   localparam int DEF_W    = 2;
   localparam int MAX_BITS = 64;

   // Vectors are zero-extended to MAX_BITS so one function serves every N/W up to 64 bits total.
   function automatic logic neighbour_ok(input logic [MAX_BITS-1:0] ring,
                                         input logic [MAX_BITS-1:0] refv,
                                         input int n,
                                         input int w);
      logic [MAX_BITS-1:0] mask;
      logic                ok;
      mask = (MAX_BITS'(1) << w) - MAX_BITS'(1);
      ok   = 1'b1;
      for (int j = 0; j < n; j++) begin
         for (int i = 0; i < n; i++) begin
            if ((((ring >> (j * w)) & mask) == ((refv >> (i * w)) & mask)) &&
                (((ring >> (((j + 1) % n) * w)) & mask) != ((refv >> (((i + 1) % n) * w)) & mask)))
               ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/ring_aligner_rotator.sv
// rtl/ring_aligner_rotator.sv - ring of N W-bit entries with parallel load and down-rotate.
module ring_rotator
   import ring_aligner_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           load_en,
   input  logic [N*W-1:0] load_data,
   input  logic           rotate_en,
   output logic [N*W-1:0] ring
);

   // Entry i moves to slot i+1 and the top entry wraps into slot 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         ring <= '0;
      else if (load_en)
         ring <= load_data;
      else if (rotate_en)
         ring <= {ring[(N-1)*W-1:0], ring[N*W-1 -: W]};
   end

endmodule

// File: rtl/ring_aligner.sv
// rtl/ring_aligner.sv - finds how many down-rotations bring the ring onto the reference entries.
// Optional ASSERT_INVARIANT_EN adds the prop_ok output and a neighbour-invariant assertion.
module ring_aligner
   import ring_aligner_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [N*W-1:0]         load_data,
   input  logic                   ref_we,
   input  logic [$clog2(N)-1:0]   ref_idx,
   input  logic [W-1:0]           ref_data,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   aligned,
   output logic [$clog2(N)-1:0]   rot_count,
   output logic [N*W-1:0]         ring_out
`ifdef ASSERT_INVARIANT_EN
   ,
   output logic                   prop_ok
`endif
);

   localparam int CW = $clog2(N);

   state_t          state_q, state_d;
   logic [CW-1:0]   k_q, k_d;
   logic [CW-1:0]   rot_q, rot_d;
   logic            aligned_q, aligned_d;
   logic [N*W-1:0]  ref_q;
   logic            load_en, rotate_en, match;

   ring_rotator #(.N(N), .W(W)) u_rotator (
      .clock     (clock),
      .reset_n   (reset_n),
      .load_en   (load_en),
      .load_data (load_data),
      .rotate_en (rotate_en),
      .ring      (ring_out)
   );

   assign match     = (ring_out == ref_q);
   assign load_en   = load_valid && load_ready;
   assign aligned   = aligned_q;
   assign rot_count = rot_q;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      rot_d      = rot_q;
      aligned_d  = aligned_q;
      rotate_en  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      load_ready = 1'b0;
      case (state_q)
         IDLE: begin
            load_ready = 1'b1;
            if (start) begin
               state_d   = SEARCH;
               k_d       = '0;
               rot_d     = '0;
               aligned_d = 1'b0;
            end
         end
         SEARCH: begin
            busy = 1'b1;
            if (match) begin
               state_d   = DONE;
               aligned_d = 1'b1;
               rot_d     = k_q;
            end else begin
               // The final rotation restores the pre-search contents.
               rotate_en = 1'b1;
               if (k_q == CW'(N - 1)) begin
                  state_d   = DONE;
                  aligned_d = 1'b0;
                  rot_d     = '0;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         rot_q     <= '0;
         aligned_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         rot_q     <= rot_d;
         aligned_q <= aligned_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         ref_q <= '0;
      else if (state_q == IDLE && ref_we && int'(ref_idx) < N)
         ref_q[ref_idx*W +: W] <= ref_data;
   end

`ifdef ASSERT_INVARIANT_EN
   assign prop_ok = neighbour_ok(MAX_BITS'(ring_out), MAX_BITS'(ref_q), N, W);

   a_neighbour: assert property (@(posedge clock) disable iff (!reset_n) prop_ok)
      else $error("ring_aligner: neighbour invariant violated");
`endif

endmodule

// File: tb/tb_ring_aligner.sv
// tb/tb_ring_aligner.sv - directed self-checking bench for ring_aligner (N=4, W=2).
module tb_ring_aligner;
   import ring_aligner_pkg::*;

   localparam int N  = 4;
   localparam int W  = 2;
   localparam int CW = 2;

   logic          clock;
   logic          reset_n;
   logic          load_valid;
   logic          load_ready;
   logic [N*W-1:0] load_data;
   logic          ref_we;
   logic [CW-1:0] ref_idx;
   logic [W-1:0]  ref_data;
   logic          start;
   logic          busy;
   logic          done;
   logic          aligned;
   logic [CW-1:0] rot_count;
   logic [N*W-1:0] ring_out;
`ifdef ASSERT_INVARIANT_EN
   logic          prop_ok;
`endif

   int checks = 0;
   int errors = 0;

   ring_aligner #(.N(N), .W(W)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .ref_we     (ref_we),
      .ref_idx    (ref_idx),
      .ref_data   (ref_data),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .aligned    (aligned),
      .rot_count  (rot_count),
      .ring_out   (ring_out)
`ifdef ASSERT_INVARIANT_EN
      ,
      .prop_ok    (prop_ok)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] pack4(input logic [1:0] a0, input logic [1:0] a1,
                                        input logic [1:0] a2, input logic [1:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic load_ring(input logic [7:0] d);
      load_valid = 1'b1;
      load_data  = d;
      @(negedge clock);
      load_valid = 1'b0;
   endtask

   task automatic write_ref(input logic [7:0] d);
      for (int i = 0; i < N; i++) begin
         ref_we   = 1'b1;
         ref_idx  = CW'(i);
         ref_data = d[i*2 +: 2];
         @(negedge clock);
      end
      ref_we = 1'b0;
   endtask

   // cyc counts cycles from the start cycle to the cycle in which done is seen (20 = timeout).
   task automatic start_and_wait(output int cyc);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; load_valid = 1'b0; load_data = '0; ref_we = 1'b0;
      ref_idx = '0; ref_data = '0; start = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL reset_aligned: got %b expected 0", aligned); end
      checks++; if (rot_count !== 2'd0) begin errors++; $display("FAIL reset_rot: got %0d expected 0", rot_count); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
      checks++; if (ring_out !== 8'h00) begin errors++; $display("FAIL reset_ring: got %h expected 00", ring_out); end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_match_k0;
      int cyc;
      load_ring(pack4(3, 0, 1, 2));
      write_ref(pack4(3, 0, 1, 2));
      start_and_wait(cyc);
      checks++; if (cyc !== 2) begin errors++; $display("FAIL k0_latency: got %0d expected 2", cyc); end
      checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL k0_aligned: got %b expected 1", aligned); end
      checks++; if (rot_count !== 2'd0) begin errors++; $display("FAIL k0_rot: got %0d expected 0", rot_count); end
      checks++; if (ring_out !== pack4(3, 0, 1, 2)) begin errors++; $display("FAIL k0_ring: got %h expected %h", ring_out, pack4(3, 0, 1, 2)); end
      @(negedge clock);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL k0_done_pulse: got %b expected 0", done); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL k0_back_idle: got %b expected 1", load_ready); end
      checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL k0_aligned_hold: got %b expected 1", aligned); end
   endtask

   task automatic test_match_k1;
      int cyc;
      load_ring(pack4(0, 1, 2, 3));
      write_ref(pack4(3, 0, 1, 2));
      start_and_wait(cyc);
      checks++; if (cyc !== 3) begin errors++; $display("FAIL k1_latency: got %0d expected 3", cyc); end
      checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL k1_aligned: got %b expected 1", aligned); end
      checks++; if (rot_count !== 2'd1) begin errors++; $display("FAIL k1_rot: got %0d expected 1", rot_count); end
      checks++; if (ring_out !== pack4(3, 0, 1, 2)) begin errors++; $display("FAIL k1_ring: got %h expected %h", ring_out, pack4(3, 0, 1, 2)); end
      @(negedge clock);
   endtask

   task automatic test_no_match;
      int cyc;
      load_ring(8'h00);
      write_ref(pack4(1, 0, 0, 0));
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1;
      checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL nm_aligned_cleared: got %b expected 0", aligned); end
      checks++; if (rot_count !== 2'd0) begin errors++; $display("FAIL nm_rot_cleared: got %0d expected 0", rot_count); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nm_busy: got %b expected 1", busy); end
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      checks++; if (cyc !== 5) begin errors++; $display("FAIL nm_latency: got %0d expected 5", cyc); end
      checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL nm_aligned: got %b expected 0", aligned); end
      checks++; if (rot_count !== 2'd0) begin errors++; $display("FAIL nm_rot: got %0d expected 0", rot_count); end
      checks++; if (ring_out !== 8'h00) begin errors++; $display("FAIL nm_ring: got %h expected 00", ring_out); end
      @(negedge clock);
   endtask

   task automatic test_ignored_inputs;
      int cyc;
      load_ring(pack4(0, 1, 2, 3));
      write_ref(pack4(3, 0, 1, 2));
      start = 1'b1;
      @(negedge clock);
      start      = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      ref_we     = 1'b1;
      ref_idx    = 2'd0;
      ref_data   = 2'd2;
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ign_load_ready_c1: got %b expected 0", load_ready); end
      @(negedge clock);
      start = 1'b0; load_valid = 1'b0; ref_we = 1'b0;
      cyc = 2;
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ign_load_ready_c2: got %b expected 0", load_ready); end
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      checks++; if (cyc !== 3) begin errors++; $display("FAIL ign_latency: got %0d expected 3", cyc); end
      checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL ign_aligned: got %b expected 1", aligned); end
      checks++; if (rot_count !== 2'd1) begin errors++; $display("FAIL ign_rot: got %0d expected 1", rot_count); end
      checks++; if (ring_out !== pack4(3, 0, 1, 2)) begin errors++; $display("FAIL ign_ring: got %h expected %h", ring_out, pack4(3, 0, 1, 2)); end
      repeat (2) begin
         @(negedge clock);
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_queue: got busy %b expected 0", busy); end
      end
   endtask

   task automatic test_reset_mid_search;
      int cyc;
      logic saw_done;
      load_ring(pack4(0, 1, 2, 3));
      write_ref(pack4(1, 1, 1, 1));
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (ring_out !== 8'h00) begin errors++; $display("FAIL rst_ring: got %h expected 00", ring_out); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready: got %b expected 1", load_ready); end
      saw_done = done;
      repeat (3) begin
         @(negedge clock);
         saw_done = saw_done | done;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_no_done: got %b expected 0", saw_done); end
      reset_n = 1'b1;
      @(negedge clock);
      start_and_wait(cyc);
      checks++; if (cyc !== 2) begin errors++; $display("FAIL rst_zero_latency: got %0d expected 2", cyc); end
      checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL rst_zero_aligned: got %b expected 1", aligned); end
      checks++; if (rot_count !== 2'd0) begin errors++; $display("FAIL rst_zero_rot: got %0d expected 0", rot_count); end
      @(negedge clock);
   endtask

   task automatic test_invariant;
      logic r;
      r = neighbour_ok(MAX_BITS'(pack4(0, 1, 2, 3)), MAX_BITS'(pack4(2, 3, 0, 1)), N, W);
      checks++; if (r !== 1'b1) begin errors++; $display("FAIL inv_fn_ok: got %b expected 1", r); end
      r = neighbour_ok(MAX_BITS'(pack4(0, 1, 2, 3)), MAX_BITS'(pack4(0, 2, 1, 3)), N, W);
      checks++; if (r !== 1'b0) begin errors++; $display("FAIL inv_fn_bad: got %b expected 0", r); end
`ifdef ASSERT_INVARIANT_EN
      load_ring(pack4(0, 1, 2, 3));
      write_ref(pack4(2, 3, 0, 1));
      checks++; if (prop_ok !== 1'b1) begin errors++; $display("FAIL inv_prop_ok: got %b expected 1", prop_ok); end
      write_ref(pack4(0, 2, 1, 3));
      checks++; if (prop_ok !== 1'b0) begin errors++; $display("FAIL inv_prop_bad: got %b expected 0", prop_ok); end
`endif
   endtask

   initial begin
      test_reset();
      test_match_k0();
      test_match_k1();
      test_no_match();
      test_ignored_inputs();
      test_reset_mid_search();
      test_invariant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
